// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared constants, controller state and adder operand-select encoding for the mantissa divider.
// Rev 1.0
`default_nettype none

package fp_div_pkg;

  localparam int MW = 24;      // mantissa width including hidden bit
  localparam int AW = MW + 2;  // adder / remainder width
  localparam int QB = MW + 3;  // raw quotient bits (1 integer + 26 fraction)
  localparam int CW = 5;       // iteration counter width

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    NORM = 3'd3,
    DONE = 3'd4
  } state_t;

  // SEL_NEG forms ~D + 1; SEL_SUB forms R + (-D); SEL_NONE parks the adder at zero.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_NEG  = 2'd1,
    SEL_SUB  = 2'd2
  } add_sel_t;

  function automatic logic [AW-1:0] widen(input logic [MW-1:0] m);
    return {2'b00, m};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mant_div_seq_if.sv
// mant_div_seq_if: request/result bundle between the divide front end and mant_div_seq.
// Rev 1.0
`default_nettype none

interface mant_div_seq_if;
  import fp_div_pkg::*;

  logic          start;
  logic [MW-1:0] a_mant;
  logic [MW-1:0] b_mant;
  logic          flush;
  logic          busy;
  logic          done;
  logic [AW-1:0] quot;
  logic          sticky;
  logic          exp_dec;
  logic          div_zero;

  modport master (
    output start, a_mant, b_mant, flush,
    input  busy, done, quot, sticky, exp_dec, div_zero
  );

  modport slave (
    input  start, a_mant, b_mant, flush,
    output busy, done, quot, sticky, exp_dec, div_zero
  );

endinterface

`default_nettype wire

// File: rtl/mant_div_seq_cladiv.sv
// cladiv: combinational carry-lookahead adder, 4-bit lookahead groups with group-carry chain; s[SIZE] is carry out.
// Rev 1.0
`default_nettype none

module cladiv #(
  parameter int SIZE = 26
) (
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] in2,
  output logic [SIZE:0]   s
);

  localparam int NG = (SIZE + 3) / 4;
  localparam int PW = NG * 4;

  logic [PW-1:0] w_a;
  logic [PW-1:0] w_b;
  logic [PW-1:0] w_g;
  logic [PW-1:0] w_p;
  logic [PW-1:0] w_c;
  logic [PW-1:0] w_sum;
  logic [NG:0]   w_gc;
  logic          w_unused;

  assign w_a   = PW'(in1);
  assign w_b   = PW'(in2);
  assign w_g   = w_a & w_b;
  assign w_p   = w_a ^ w_b;
  assign w_gc[0] = 1'b0;

  generate
    for (genvar k = 0; k < NG; k++) begin : g_grp
      logic [3:0] w_gg;
      logic [3:0] w_pp;
      assign w_gg = w_g[4*k +: 4];
      assign w_pp = w_p[4*k +: 4];

      assign w_c[4*k]   = w_gc[k];
      assign w_c[4*k+1] = w_gg[0] | (w_pp[0] & w_gc[k]);
      assign w_c[4*k+2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_gc[k]);
      assign w_c[4*k+3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                        | (w_pp[2] & w_pp[1] & w_pp[0] & w_gc[k]);
      assign w_gc[k+1]  = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                        | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]) | ((&w_pp) & w_gc[k]);
    end
  endgenerate

  assign w_sum = w_p ^ w_c;

  // Operands are zero-padded, so the carry into bit SIZE is the true carry out.
  assign s = {w_c[SIZE], w_sum[SIZE-1:0]};

  assign w_unused = &{1'b0, w_gc[NG], w_sum[PW-1:SIZE], w_c[PW-1:SIZE+1]};

endmodule

`default_nettype wire

// File: rtl/mant_div_seq.sv
// mant_div_seq: restoring mantissa divider sharing one CLA adder; emits normalised quotient, sticky and exponent decrement.
// Rev 1.0
`default_nettype none

module mant_div_seq
  import fp_div_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mant_div_seq_if.slave  bus
);

  state_t        r_state;
  state_t        w_next;
  add_sel_t      w_sel;
  logic          w_busy;
  logic          w_done;

  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_rem;
  logic [AW-1:0] r_div;
  logic [AW-1:0] r_neg_d;
  logic [QB-1:0] r_q;

  logic [AW-1:0] r_quot;
  logic          r_sticky;
  logic          r_exp_dec;
  logic          r_div_zero;

  logic [AW-1:0] w_in1;
  logic [AW-1:0] w_in2;
  logic [AW:0]   w_sum;
  logic          w_ge;
  logic          w_accept;
  logic          w_zero_b;
  logic          w_last;

  logic [AW-1:0] w_norm_quot;
  logic          w_norm_sticky;
  logic          w_norm_exp_dec;

  assign w_accept = bus.start & ~bus.flush;
  assign w_zero_b = (bus.b_mant == '0);
  assign w_last   = (r_cnt == CW'(QB - 1));
  assign w_ge     = w_sum[AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_sel  = SEL_NONE;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_accept) begin
          w_next = w_zero_b ? DONE : LOAD;
        end
      end
      LOAD: begin
        w_sel  = SEL_NEG;
        w_next = bus.flush ? IDLE : ITER;
      end
      ITER: begin
        w_sel = SEL_SUB;
        if (bus.flush) begin
          w_next = IDLE;
        end else if (w_last) begin
          w_next = NORM;
        end
      end
      NORM: begin
        w_next = bus.flush ? IDLE : DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_in1 = '0;
    w_in2 = '0;
    case (w_sel)
      SEL_NEG: begin
        w_in1 = ~r_div;
        w_in2 = AW'(1);
      end
      SEL_SUB: begin
        w_in1 = r_rem;
        w_in2 = r_neg_d;
      end
      default: begin
        w_in1 = '0;
        w_in2 = '0;
      end
    endcase
  end

  cladiv #(
    .SIZE (AW)
  ) u_cladiv (
    .in1 (w_in1),
    .in2 (w_in2),
    .s   (w_sum)
  );

  // Quotient below 1 drops the leading zero and borrows a bit from the exponent.
  always_comb begin
    if (r_q[QB-1]) begin
      w_norm_quot    = r_q[QB-1:1];
      w_norm_sticky  = r_q[0] | (r_rem != '0);
      w_norm_exp_dec = 1'b0;
    end else begin
      w_norm_quot    = r_q[QB-2:0];
      w_norm_sticky  = (r_rem != '0);
      w_norm_exp_dec = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_neg_d    <= '0;
      r_q        <= '0;
      r_quot     <= '0;
      r_sticky   <= 1'b0;
      r_exp_dec  <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem <= widen(bus.a_mant);
            r_div <= widen(bus.b_mant);
            r_q   <= '0;
            r_cnt <= '0;
            if (w_zero_b) begin
              r_quot     <= '0;
              r_sticky   <= 1'b0;
              r_exp_dec  <= 1'b0;
              r_div_zero <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (!bus.flush) begin
            r_neg_d <= w_sum[AW-1:0];
          end
        end
        ITER: begin
          if (!bus.flush) begin
            r_q   <= {r_q[QB-2:0], w_ge};
            r_rem <= w_ge ? {w_sum[AW-2:0], 1'b0} : {r_rem[AW-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        NORM: begin
          if (!bus.flush) begin
            r_quot     <= w_norm_quot;
            r_sticky   <= w_norm_sticky;
            r_exp_dec  <= w_norm_exp_dec;
            r_div_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.quot     = r_quot;
  assign bus.sticky   = r_sticky;
  assign bus.exp_dec  = r_exp_dec;
  assign bus.div_zero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_mant_div_seq.sv
// tb_mant_div_seq: random and directed mantissa divides checked against an integer-division model.
// Rev 1.0
`default_nettype none

module tb_mant_div_seq;
  import fp_div_pkg::*;

  typedef struct packed {
    logic [AW-1:0] quot;
    logic          sticky;
    logic          exp_dec;
    logic          div_zero;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  res_t held;
  res_t mon_e;

  always #5 clk = ~clk;

  mant_div_seq_if bus ();

  mant_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // a/b scaled by 2^26 gives the 27-bit raw quotient; normalise from that.
  function automatic res_t model(input logic [MW-1:0] a, input logic [MW-1:0] b);
    res_t        r;
    logic [63:0] num;
    logic [63:0] q;
    logic [63:0] rem;
    r = '0;
    if (b == '0) begin
      r.div_zero = 1'b1;
      return r;
    end
    num = 64'(a) << AW;
    q   = num / 64'(b);
    rem = num % 64'(b);
    if (q[QB-1]) begin
      r.quot   = q[AW:1];
      r.sticky = q[0] | (rem != 0);
    end else begin
      r.quot    = q[AW-1:0];
      r.sticky  = (rem != 0);
      r.exp_dec = 1'b1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      held = '0;
      exp_q.delete();
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(bus.done), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("quot", 64'(bus.quot), 64'(mon_e.quot));
        chk("sticky", 64'(bus.sticky), 64'(mon_e.sticky));
        chk("exp_dec", 64'(bus.exp_dec), 64'(mon_e.exp_dec));
        chk("div_zero", 64'(bus.div_zero), 64'(mon_e.div_zero));
        held = mon_e;
      end
    end else begin
      chk("held_outputs", 64'({bus.quot, bus.sticky, bus.exp_dec, bus.div_zero}), 64'(held));
    end
  end

  task automatic wait_done(input int exp_lat, input string name);
    int  k;
    bit  seen;
    seen = 1'b0;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 64'(seen), 64'(1));
    if (seen) chk({name, "_latency"}, 64'(k), 64'(exp_lat));
  endtask

  task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input string name);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a_mant = a;
    bus.b_mant = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.a_mant = MW'($urandom);
    bus.b_mant = MW'($urandom);
    exp_q.push_back(model(a, b));
    chk({name, "_busy"}, 64'(bus.busy), 64'(1));
    wait_done((b == '0) ? 0 : QB + 2, name);
  endtask

  initial begin
    logic [MW-1:0] ra;
    logic [MW-1:0] rb;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.a_mant = '0;
    bus.b_mant = '0;

    chk("model_1_1", 64'(model(24'h800000, 24'h800000)), 64'({26'h2000000, 3'b000}));
    chk("model_1_1p5", 64'(model(24'h800000, 24'hC00000)), 64'({26'h2AAAAAA, 3'b110}));
    chk("model_1p5_1", 64'(model(24'hC00000, 24'h800000)), 64'({26'h3000000, 3'b000}));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'({bus.busy, bus.done, bus.quot, bus.sticky, bus.exp_dec, bus.div_zero}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op(24'h800000, 24'h800000, "one_one");
    chk("one_one_quot", 64'(bus.quot), 64'h2000000);
    chk("one_one_flags", 64'({bus.sticky, bus.exp_dec, bus.div_zero}), 64'(0));
    run_op(24'h800000, 24'hC00000, "one_1p5");
    chk("one_1p5_quot", 64'(bus.quot), 64'h2AAAAAA);
    chk("one_1p5_flags", 64'({bus.sticky, bus.exp_dec}), 64'(3));
    run_op(24'hC00000, 24'h800000, "1p5_one");
    chk("1p5_one_quot", 64'(bus.quot), 64'h3000000);
    run_op(24'h800000, 24'h000000, "div0");
    chk("div0_flag", 64'({bus.div_zero, bus.quot}), 64'({1'b1, 26'h0}));

    // Start held through the done cycle: accepted only on the following IDLE cycle.
    bus.start  = 1'b1;
    bus.a_mant = 24'hFFFFFF;
    bus.b_mant = 24'h800001;
    @(posedge clk);
    #1;
    chk("b2b_not_accepted", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_accepted", 64'(bus.busy), 64'(1));
    exp_q.push_back(model(24'hFFFFFF, 24'h800001));
    wait_done(QB + 2, "b2b");

    for (int i = 0; i < 20; i++) begin
      ra = MW'($urandom) | 24'h800000;
      rb = MW'($urandom) | 24'h800000;
      if (i % 3 == 0) rb = 24'h800000 | MW'($urandom_range(0, 15));
      if (i == 7) rb = '0;
      run_op(ra, rb, "rand");
    end

    // Flush mid-iteration with an ignored start pulse in flight.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a_mant = 24'h800000;
    bus.b_mant = 24'hC00000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      #1;
      if (e == 4) begin
        bus.start  = 1'b1;
        bus.a_mant = 24'hABCDEF;
        bus.b_mant = 24'h900000;
      end
      if (e == 6) bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    chk("flush_busy_before", 64'(bus.busy), 64'(1));
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_idle", 64'(bus.busy), 64'(0));
    repeat (40) @(negedge clk);

    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_wins", 64'(bus.busy), 64'(0));

    run_op(24'hC00000, 24'h800000, "pre_rst");

    @(negedge clk);
    bus.start  = 1'b1;
    bus.a_mant = 24'hC00000;
    bus.b_mant = 24'hA00000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 64'({bus.busy, bus.done, bus.quot, bus.sticky, bus.exp_dec, bus.div_zero}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(24'h800000, 24'h800000, "post_rst");
    chk("post_rst_quot", 64'(bus.quot), 64'h2000000);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
